// File: rtl/frame_painter_pkg.sv
// Shared definitions for the frame painter: screen geometry defaults,
// RGB111 colour constants and the command FSM state encoding.
package frame_painter_pkg;

  localparam int SCREEN_X_DEF = 176;
  localparam int SCREEN_Y_DEF = 120;
  localparam int AW_DEF       = 15;
  localparam int DW_DEF       = 3;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    FILL   = 2'd2,
    FINISH = 2'd3
  } painter_state_t;

endpackage

// File: rtl/frame_painter_rect_scan.sv
// Raster scanner for one rectangle: walks x across each row and steps the
// row base by SCREEN_X at every row change, so the fill loop only adds.
// Flags the last pixel of the rectangle for the controlling FSM.
module rect_scan
  import frame_painter_pkg::*;
#(
  parameter int SCREEN_X = SCREEN_X_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [8:0]    x_start,
  input  logic [7:0]    y_start,
  input  logic [8:0]    x_end,
  input  logic [7:0]    y_end,
  input  logic [AW-1:0] base_start,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [8:0]    x;
  logic [7:0]    y;
  logic [8:0]    x_first;
  logic [8:0]    x_last;
  logic [7:0]    y_last;
  logic [AW-1:0] row_base;

  // Load a new rectangle, or step one pixel in row-major order.
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      x_first  <= '0;
      x_last   <= '0;
      y_last   <= '0;
      row_base <= '0;
    end else if (load) begin
      x        <= x_start;
      y        <= y_start;
      x_first  <= x_start;
      x_last   <= x_end - 9'd1;
      y_last   <= y_end - 8'd1;
      row_base <= base_start;
    end else if (advance) begin
      if (x == x_last) begin
        x        <= x_first;
        y        <= y + 8'd1;
        row_base <= row_base + AW'(SCREEN_X);
      end else begin
        x <= x + 9'd1;
      end
    end
  end

  assign addr = row_base + AW'(x);
  assign last = (x == x_last) && (y == y_last);

endmodule

// File: rtl/frame_painter.sv
// Rectangle / clear-screen fill engine writing one pixel per clock into a
// dual-port frame buffer. Optional macro PAINTER_CLIP_EN clips rectangles
// to the screen instead of rejecting out-of-range ones with err.
module frame_painter
  import frame_painter_pkg::*;
#(
  parameter int SCREEN_X = SCREEN_X_DEF,
  parameter int SCREEN_Y = SCREEN_Y_DEF,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_clear,
  input  logic [7:0]    cmd_x0,
  input  logic [6:0]    cmd_y0,
  input  logic [7:0]    cmd_w,
  input  logic [6:0]    cmd_h,
  input  logic [DW-1:0] cmd_color,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr
);

  localparam logic [8:0] SX9 = 9'(SCREEN_X);
  localparam logic [7:0] SY8 = 8'(SCREEN_Y);

  painter_state_t state, state_next;

  logic          clear_q;
  logic [7:0]    x0_q;
  logic [6:0]    y0_q;
  logic [7:0]    w_q;
  logic [6:0]    h_q;
  logic [DW-1:0] color_q;

  logic [8:0]    x_sum;
  logic [7:0]    y_sum;
  logic [8:0]    x_start;
  logic [7:0]    y_start;
  logic [8:0]    x_end;
  logic [7:0]    y_end;
  logic [AW-1:0] base_start;
  logic          out_of_range;
  logic          empty;

  logic          scan_load;
  logic          scan_advance;
  logic [AW-1:0] scan_addr;
  logic          scan_last;

  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the whole command when it is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      clear_q <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else if (state == IDLE && cmd_valid) begin
      clear_q <= cmd_clear;
      x0_q    <= cmd_x0;
      y0_q    <= cmd_y0;
      w_q     <= cmd_w;
      h_q     <= cmd_h;
      color_q <= cmd_color;
    end
  end

  // Bounds for the scan, widened one bit so x0+w and y0+h cannot overflow.
  always_comb begin
    x_sum   = {1'b0, x0_q} + {1'b0, w_q};
    y_sum   = {1'b0, y0_q} + {1'b0, h_q};
    x_start = clear_q ? 9'd0 : {1'b0, x0_q};
    y_start = clear_q ? 8'd0 : {1'b0, y0_q};
`ifdef PAINTER_CLIP_EN
    x_end        = clear_q ? SX9 : ((x_sum > SX9) ? SX9 : x_sum);
    y_end        = clear_q ? SY8 : ((y_sum > SY8) ? SY8 : y_sum);
    out_of_range = 1'b0;
`else
    x_end        = clear_q ? SX9 : x_sum;
    y_end        = clear_q ? SY8 : y_sum;
    out_of_range = !clear_q && ((x_sum > SX9) || (y_sum > SY8));
`endif
    empty      = (x_end <= x_start) || (y_end <= y_start);
    base_start = AW'(y_start) * AW'(SCREEN_X);
  end

  rect_scan #(
    .SCREEN_X (SCREEN_X),
    .AW       (AW)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .load       (scan_load),
    .advance    (scan_advance),
    .x_start    (x_start),
    .y_start    (y_start),
    .x_end      (x_end),
    .y_end      (y_end),
    .base_start (base_start),
    .addr       (scan_addr),
    .last       (scan_last)
  );

  // Next-state and handshake/status outputs.
  always_comb begin
    state_next   = state;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    px_wr        = 1'b0;
    scan_load    = 1'b0;
    scan_advance = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = SETUP;
      end
      SETUP: begin
        scan_load = 1'b1;
        if (out_of_range) begin
          err        = 1'b1;
          state_next = IDLE;
        end else if (empty) begin
          state_next = FINISH;
        end else begin
          state_next = FILL;
        end
      end
      FILL: begin
        px_wr        = 1'b1;
        scan_advance = 1'b1;
        if (scan_last) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Remember the last written pixel so the write port holds between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_addr <= '0;
      hold_data <= '0;
    end else if (px_wr) begin
      hold_addr <= scan_addr;
      hold_data <= color_q;
    end
  end

  assign mem_px_addr = px_wr ? scan_addr : hold_addr;
  assign mem_px_data = px_wr ? color_q   : hold_data;

endmodule

// File: tb/tb_frame_painter.sv
// Self-checking bench for frame_painter: expected pixel writes are queued
// when a command is issued and popped by a write monitor as they appear.
module tb_frame_painter;
  import frame_painter_pkg::*;

  localparam int SX  = 176;
  localparam int SY  = 120;
  localparam int AWT = 15;
  localparam int DWT = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_clear = 1'b0;
  logic [7:0]     cmd_x0 = '0;
  logic [6:0]     cmd_y0 = '0;
  logic [7:0]     cmd_w = '0;
  logic [6:0]     cmd_h = '0;
  logic [DWT-1:0] cmd_color = '0;
  logic           cmd_ready, busy, done, err, px_wr;
  logic [AWT-1:0] mem_px_addr;
  logic [DWT-1:0] mem_px_data;

  int errors = 0;
  int checks = 0;
  logic [AWT+DWT-1:0] exp_q[$];

  always #5 clk = ~clk;

  frame_painter #(
    .SCREEN_X (SX),
    .SCREEN_Y (SY),
    .AW       (AWT),
    .DW       (DWT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_clear   (cmd_clear),
    .cmd_x0      (cmd_x0),
    .cmd_y0      (cmd_y0),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .cmd_color   (cmd_color),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr)
  );

  // Write monitor: every px_wr must match the head of the expected queue.
  always @(negedge clk) begin
    logic [AWT+DWT-1:0] e;
    if (px_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL write_unexpected got addr=%0d data=%b", mem_px_addr, mem_px_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_px_addr, mem_px_data} !== e) begin
          errors++;
          $display("[TB] FAIL write got addr=%0d data=%b exp addr=%0d data=%b",
                   mem_px_addr, mem_px_data, e[AWT+DWT-1:DWT], e[DWT-1:0]);
        end
      end
    end
  end

  task automatic push_rect(input int x0, input int y0, input int w, input int h,
                           input logic [DWT-1:0] c);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        exp_q.push_back({AWT'(y * SX + x), c});
  endtask

  task automatic issue(input logic clr, input int x0, input int y0, input int w,
                       input int h, input logic [DWT-1:0] c);
    @(negedge clk);
    cmd_clear = clr;
    cmd_x0    = 8'(x0);
    cmd_y0    = 7'(y0);
    cmd_w     = 8'(w);
    cmd_h     = 7'(h);
    cmd_color = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits from the first cycle after accept; cyc is cycles since accept.
  task automatic wait_end(input int max, output int cyc, output bit got_done,
                          output bit got_err);
    cyc = 1;
    got_done = 1'b0;
    got_err = 1'b0;
    while (cyc <= max) begin
      if (done === 1'b1) begin got_done = 1'b1; break; end
      if (err === 1'b1) begin got_err = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 7;
    if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got=%b exp=1", cmd_ready); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got=%b exp=0", done); end
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err got=%b exp=0", err); end
    if (px_wr !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr got=%b exp=0", px_wr); end
    if (mem_px_addr !== '0) begin errors++; $display("[TB] FAIL rst_addr got=%0d exp=0", mem_px_addr); end
    if (mem_px_data !== '0) begin errors++; $display("[TB] FAIL rst_data got=%b exp=000", mem_px_data); end
    rst = 1'b0;
  endtask

  task automatic test_clear();
    int cyc; bit gd, ge;
    for (int a = 0; a < SX * SY; a++) exp_q.push_back({AWT'(a), BLUE});
    issue(1'b1, 50, 60, 10, 10, BLUE);
    wait_end(21300, cyc, gd, ge);
    checks += 6;
    if (!gd || cyc != 21122) begin errors++; $display("[TB] FAIL clear_done got done=%0d cyc=%0d exp done=1 cyc=21122", gd, cyc); end
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL clear_left got=%0d exp=0", exp_q.size()); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL clear_busy_finish got=%b exp=1", busy); end
    if (mem_px_addr !== AWT'(21119)) begin errors++; $display("[TB] FAIL clear_hold_addr got=%0d exp=21119", mem_px_addr); end
    if (mem_px_data !== BLUE) begin errors++; $display("[TB] FAIL clear_hold_data got=%b exp=001", mem_px_data); end
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
    exp_q.delete();
  endtask

  task automatic test_rect();
    int cyc; bit gd, ge;
    int addrs[6] = '{890, 891, 892, 1066, 1067, 1068};
    foreach (addrs[i]) exp_q.push_back({AWT'(addrs[i]), RED});
    issue(1'b0, 10, 5, 3, 2, RED);
    wait_end(50, cyc, gd, ge);
    checks += 3;
    if (!gd || cyc != 8) begin errors++; $display("[TB] FAIL rect_done got done=%0d cyc=%0d exp done=1 cyc=8", gd, cyc); end
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rect_left got=%0d exp=0", exp_q.size()); end
    if (mem_px_addr !== AWT'(1068)) begin errors++; $display("[TB] FAIL rect_hold_addr got=%0d exp=1068", mem_px_addr); end
    exp_q.delete();
  endtask

  task automatic test_zero();
    int cyc; bit gd, ge;
    issue(1'b0, 10, 5, 0, 7, GREEN);
    wait_end(50, cyc, gd, ge);
    checks++;
    if (!gd || ge || cyc != 2) begin errors++; $display("[TB] FAIL zero_w got done=%0d cyc=%0d exp done=1 cyc=2", gd, cyc); end
    issue(1'b0, 20, 9, 5, 0, GREEN);
    wait_end(50, cyc, gd, ge);
    checks++;
    if (!gd || ge || cyc != 2) begin errors++; $display("[TB] FAIL zero_h got done=%0d cyc=%0d exp done=1 cyc=2", gd, cyc); end
  endtask

  task automatic test_offscreen();
    int cyc; bit gd, ge; bit saw_done;
`ifdef PAINTER_CLIP_EN
    push_rect(170, 118, 6, 2, WHITE);
    issue(1'b0, 170, 118, 10, 4, WHITE);
    wait_end(60, cyc, gd, ge);
    checks += 2;
    if (!gd || ge || cyc != 14) begin errors++; $display("[TB] FAIL clip_done got done=%0d err=%0d cyc=%0d exp done=1 cyc=14", gd, ge, cyc); end
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL clip_left got=%0d exp=0", exp_q.size()); end
    issue(1'b0, 200, 10, 5, 5, WHITE);
    wait_end(60, cyc, gd, ge);
    checks++;
    if (!gd || ge || cyc != 2) begin errors++; $display("[TB] FAIL clip_off got done=%0d err=%0d cyc=%0d exp done=1 cyc=2", gd, ge, cyc); end
    saw_done = 1'b0;
`else
    issue(1'b0, 170, 118, 10, 4, WHITE);
    wait_end(60, cyc, gd, ge);
    checks++;
    if (!ge || gd || cyc != 1) begin errors++; $display("[TB] FAIL reject_err got err=%0d done=%0d cyc=%0d exp err=1 cyc=1", ge, gd, cyc); end
    saw_done = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL reject_idle got ready=%b err=%b exp 1 0", cmd_ready, err); end
    repeat (6) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
`endif
    checks++;
    if (saw_done) begin errors++; $display("[TB] FAIL reject_no_done got=1 exp=0"); end
  endtask

  task automatic test_reset_mid_fill();
    int cyc; bit gd, ge;
    for (int a = 0; a < SX * SY; a++) exp_q.push_back({AWT'(a), GREEN});
    issue(1'b1, 0, 0, 0, 0, GREEN);
    repeat (50) @(negedge clk);
    checks++;
    if (px_wr !== 1'b1 || mem_px_addr !== AWT'(49)) begin errors++; $display("[TB] FAIL mid_50th got wr=%b addr=%0d exp wr=1 addr=49", px_wr, mem_px_addr); end
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (px_wr !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_rst got wr=%b busy=%b ready=%b done=%b exp 0 0 1 0", px_wr, busy, cmd_ready, done);
    end
    if (mem_px_addr !== '0) begin errors++; $display("[TB] FAIL mid_rst_addr got=%0d exp=0", mem_px_addr); end
    if (exp_q.size() != SX * SY - 50) begin errors++; $display("[TB] FAIL mid_count got=%0d exp=%0d", exp_q.size(), SX * SY - 50); end
    exp_q.delete();
    rst = 1'b0;
    push_rect(3, 4, 2, 2, RED);
    issue(1'b0, 3, 4, 2, 2, RED);
    wait_end(50, cyc, gd, ge);
    checks += 2;
    if (!gd || cyc != 6) begin errors++; $display("[TB] FAIL mid_after got done=%0d cyc=%0d exp done=1 cyc=6", gd, cyc); end
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL mid_after_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit gd, ge; bit ready_bad;
    push_rect(20, 30, 4, 2, RED);
    push_rect(40, 50, 3, 3, BLUE);
    @(negedge clk);
    cmd_clear = 1'b0; cmd_x0 = 8'd20; cmd_y0 = 7'd30; cmd_w = 8'd4; cmd_h = 7'd2;
    cmd_color = RED; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_x0 = 8'd40; cmd_y0 = 7'd50; cmd_w = 8'd3; cmd_h = 7'd3; cmd_color = BLUE;
    cyc = 1; gd = 1'b0; ready_bad = 1'b0;
    while (cyc <= 30 && !gd) begin
      if (busy === 1'b1 && cmd_ready !== 1'b0) ready_bad = 1'b1;
      if (done === 1'b1) gd = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    checks += 4;
    if (!gd || cyc != 10) begin errors++; $display("[TB] FAIL b2b_first got done=%0d cyc=%0d exp done=1 cyc=10", gd, cyc); end
    if (ready_bad) begin errors++; $display("[TB] FAIL b2b_ready_busy got=1 exp=0"); end
    if (exp_q.size() != 9) begin errors++; $display("[TB] FAIL b2b_first_left got=%0d exp=9", exp_q.size()); end
    @(negedge clk);
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got ready=%b busy=%b exp 1 0", cmd_ready, busy); end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_end(50, cyc, gd, ge);
    checks += 2;
    if (!gd || cyc != 11) begin errors++; $display("[TB] FAIL b2b_second got done=%0d cyc=%0d exp done=1 cyc=11", gd, cyc); end
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_random_rects();
    int cyc; bit gd, ge; int x0, y0, w, h;
    logic [DWT-1:0] c;
    for (int n = 0; n < 4; n++) begin
      x0 = $urandom_range(0, 160); w = $urandom_range(1, 16);
      y0 = $urandom_range(0, 110); h = $urandom_range(1, 10);
      c = DWT'($urandom_range(0, 7));
      push_rect(x0, y0, w, h, c);
      issue(1'b0, x0, y0, w, h, c);
      wait_end(400, cyc, gd, ge);
      checks += 2;
      if (!gd || cyc != 2 + w * h) begin errors++; $display("[TB] FAIL rand_done got done=%0d cyc=%0d exp cyc=%0d", gd, cyc, 2 + w * h); end
      if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rand_left got=%0d exp=0", exp_q.size()); end
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_rect();
    test_zero();
    test_offscreen();
    test_back_to_back();
    test_random_rects();
    test_clear();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_painter.md
FRAME_PAINTER -- requirements
Module: frame_painter

Interface
REQ-001 SHALL have parameter SCREEN_X, default 176, framebuffer width in pixels.
REQ-002 SHALL have parameter SCREEN_Y, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter AW, default 15, pixel address width.
REQ-004 SHALL have parameter DW, default 3, pixel width (RGB111, bit2=R, bit1=G, bit0=B).
REQ-005 SHALL have port clk  in  1  single clock (25 MHz pixel clock domain).
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port cmd_valid  in  1  command request.
REQ-008 SHALL have port cmd_ready  out  1  engine can accept a command.
REQ-009 SHALL have port cmd_clear  in  1  1 = fill whole screen; ignores the coordinate inputs.
REQ-010 SHALL have ports cmd_x0 (in, 8), cmd_y0 (in, 7), cmd_w (in, 8), cmd_h (in, 7): rectangle origin and size.
REQ-011 SHALL have port cmd_color  in  DW  fill colour.
REQ-012 SHALL have port busy  out  1  command in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse at command completion.
REQ-014 SHALL have port err  out  1  one-cycle pulse on a rejected command.
REQ-015 SHALL have ports mem_px_addr (out, AW), mem_px_data (out, DW), px_wr (out, 1): write port to the dual-port frame buffer.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, FILL, FINISH.
REQ-017 IDLE: cmd_ready=1; cmd_valid=1 SHALL register all command fields and move to SETUP; cmd_valid SHALL be ignored in every other state.
REQ-018 SETUP (1 cycle): SHALL compute the row/column end bounds and the row base y0*SCREEN_X, then go to FILL, or go to FINISH if the effective width or height is 0.
REQ-019 FILL: SHALL write one pixel per cycle in row-major order, with px_wr=1, mem_px_addr=x+y*SCREEN_X and mem_px_data=registered colour.
REQ-020 SHALL update the row base incrementally (+SCREEN_X per row); no multiplier SHALL be used in FILL.
REQ-021 First px_wr SHALL occur 2 cycles after the accept cycle; a w*h rectangle SHALL take exactly w*h write cycles.
REQ-022 FINISH: done=1 for one cycle, then IDLE; busy=1 in SETUP, FILL and FINISH.
REQ-023 cmd_clear SHALL write addresses 0..SCREEN_X*SCREEN_Y-1 (0..21119 at defaults) in ascending order.
REQ-024 px_wr SHALL be 0 in every state other than FILL; mem_px_addr and mem_px_data SHALL hold their last values when px_wr=0.
REQ-025 Rectangle end coordinates SHALL be computed 1 bit wider than the inputs, so x0+w and y0+h do not overflow.

Reset
REQ-026 rst SHALL force IDLE on the next clk edge, including mid-FILL; a partial fill SHALL be abandoned and no done is produced.
REQ-027 Reset values SHALL be: cmd_ready=1, busy=0, done=0, err=0, px_wr=0, mem_px_addr=0, mem_px_data=0.

Configuration
REQ-028 With PAINTER_CLIP_EN defined: rectangles SHALL be clipped to the screen (x_end=min(x0+w,SCREEN_X), y_end=min(y0+h,SCREEN_Y)); a fully off-screen rectangle SHALL give zero writes then done; err SHALL stay 0.
REQ-029 Without PAINTER_CLIP_EN: if x0+w>SCREEN_X or y0+h>SCREEN_Y, SETUP SHALL pulse err for one cycle, do no writes, pulse no done, and return to IDLE.

Structure
REQ-030 A shared package SHALL hold SCREEN_X/SCREEN_Y/AW/DW defaults, the RGB111 colour constants (RED 3'b100, GREEN 3'b010, BLUE 3'b001) and the FSM state encoding.
REQ-031 A sub-module rect_scan SHALL generate the x/y/row-base counters and a last-pixel flag; frame_painter SHALL hold the FSM and the command registers.

Verification
REQ-032 After reset, cmd_clear=1, colour 3'b001 -> 21120 writes at addr 0..21119, data 001, done 21122 cycles after the accept cycle.
REQ-033 Command x0=10, y0=5, w=3, h=2, colour 100 -> writes at 890,891,892,1066,1067,1068, then done.
REQ-034 Command w=0, h=7 -> no px_wr; done 2 cycles after accept.
REQ-035 Command x0=170, y0=118, w=10, h=4 -> with PAINTER_CLIP_EN: 12 writes (x 170..175, y 118..119); without it: err pulse, no writes, no done.
REQ-036 rst asserted during the 50th write of a clear -> next cycle px_wr=0, busy=0, cmd_ready=1; a new command is accepted normally.
REQ-037 cmd_valid held high during FILL -> second command not accepted until IDLE; cmd_ready=0 throughout busy.
